// File: rtl/sdfa_neuron_array.sv
// sdfa_neuron_array: multi-channel saturating spike accumulator with block threshold and read handshake (optional leak via SDFA_NEURON_LEAK_EN)
module sdfa_neuron_array #(
   parameter int NUM_CH     = 4,
   parameter int W_WIDTH    = 9,
   parameter int ACC_WIDTH  = 10,
   parameter int BLOCK_LEN  = 16,
   parameter int LEAK_SHIFT = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cal_en,
   input  logic                           new_block,
   input  logic                           input_spike,
   input  logic [NUM_CH*W_WIDTH-1:0]      weight,
   input  logic [ACC_WIDTH-1:0]           threshold,
   input  logic                           read_done,
   output logic [NUM_CH*ACC_WIDTH-1:0]    sum,
   output logic [NUM_CH-1:0]              out_spike,
   output logic                           cal_done,
   output logic                           busy
);
   localparam int CW = $clog2(BLOCK_LEN + 1);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_step;
   logic [NUM_CH*ACC_WIDTH-1:0] sum_nx, step_sum;
   logic [NUM_CH-1:0] spike_nx, fire;
   logic done_nx, accept, last;
   if (BLOCK_LEN < 1 || ACC_WIDTH < W_WIDTH || LEAK_SHIFT < 0) begin : g_bad_param
      $error("sdfa_neuron_array: illegal parameter combination");
   end
   // new_block behaves as a clear to IDLE, so a coincident step starts from zero
   assign accept   = cal_en && (new_block || state != DONE);
   assign cnt_step = (new_block ? {CW{1'b0}} : cnt) + CW'(1);
   assign last     = cnt_step == CW'(BLOCK_LEN);
   assign busy     = state == ACCUM;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic signed [ACC_WIDTH-1:0] base, leaked, sat;
      logic signed [ACC_WIDTH:0]   raw, addend;
      logic [W_WIDTH-1:0]          w;
      assign w      = weight[i*W_WIDTH +: W_WIDTH];
      assign base   = new_block ? '0 : sum[i*ACC_WIDTH +: ACC_WIDTH];
`ifdef SDFA_NEURON_LEAK_EN
      assign leaked = base - (base >>> LEAK_SHIFT);
`else
      assign leaked = base;
`endif
      assign addend = input_spike ? {{(ACC_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w} : '0;
      assign raw    = {leaked[ACC_WIDTH-1], leaked} + addend;
      // one extra bit exposes overflow; clamp to the representable extreme
      assign sat    = (raw[ACC_WIDTH] == raw[ACC_WIDTH-1]) ? raw[ACC_WIDTH-1:0]
                    : {raw[ACC_WIDTH], {(ACC_WIDTH-1){~raw[ACC_WIDTH]}}};
      assign step_sum[i*ACC_WIDTH +: ACC_WIDTH] = sat;
      assign fire[i] = sat >= $signed(threshold);
   end
   // next-state: clear on new_block or acknowledged read, then apply an accepted step
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      sum_nx   = sum;
      spike_nx = out_spike;
      done_nx  = cal_done;
      if (new_block || (state == DONE && read_done)) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         sum_nx   = '0;
         spike_nx = '0;
         done_nx  = 1'b0;
      end
      if (accept) begin
         cnt_nx   = cnt_step;
         sum_nx   = step_sum;
         state_nx = last ? DONE : ACCUM;
         spike_nx = last ? fire : '0;
         done_nx  = last;
      end
   end
   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sum       <= '0;
         out_spike <= '0;
         cal_done  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         sum       <= sum_nx;
         out_spike <= spike_nx;
         cal_done  <= done_nx;
      end
   end
endmodule
